// File: rtl/css_mcu0_el2_pkg.sv
// Shared types for the EL2 decode-side GPR writeback path.
package css_mcu0_el2_pkg;

  localparam int GPR_WB_PORTS = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } el2_gpr_wb_req_t;

endpackage

// File: rtl/css_mcu0_el2_dec_gpr_wb_arb_chk.sv
// Port-level protocol checks for the GPR writeback arbiter.
module css_mcu0_el2_dec_gpr_wb_arb_chk (
  input logic       clk,
  input logic       rst_l,
  input logic       wen0,
  input logic       wen1,
  input logic       wen2,
  input logic [4:0] waddr0,
  input logic [4:0] waddr1,
  input logic [4:0] waddr2
);

  a_no_dup_01: assert property (@(posedge clk) disable iff (!rst_l) !(wen0 && wen1 && (waddr0 == waddr1)));
  a_no_dup_02: assert property (@(posedge clk) disable iff (!rst_l) !(wen0 && wen2 && (waddr0 == waddr2)));
  a_no_dup_12: assert property (@(posedge clk) disable iff (!rst_l) !(wen1 && wen2 && (waddr1 == waddr2)));
  a_no_x0_0:   assert property (@(posedge clk) disable iff (!rst_l) !(wen0 && (waddr0 == 5'd0)));
  a_no_x0_1:   assert property (@(posedge clk) disable iff (!rst_l) !(wen1 && (waddr1 == 5'd0)));
  a_no_x0_2:   assert property (@(posedge clk) disable iff (!rst_l) !(wen2 && (waddr2 == 5'd0)));

endmodule

// File: rtl/css_mcu0_el2_gpr_wb_fifo.sv
// Per-source writeback request FIFO; exposes every slot's address and validity
// so the arbiter can build the pending-write map.
module css_mcu0_el2_gpr_wb_fifo
  import css_mcu0_el2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  el2_gpr_wb_req_t       i_wr_req,
  output logic                  o_full,
  output logic                  o_empty,
  output el2_gpr_wb_req_t       o_head,
  output logic [DEPTH-1:0]      o_ent_valid,
  output logic [DEPTH-1:0][4:0] o_ent_addr
);

  localparam int PW = $clog2(DEPTH);

  el2_gpr_wb_req_t r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == (PW+1)'(0));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // entry storage, one load enable per slot
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_push && (r_wr_ptr == PW'(k))) r_mem[k] <= i_wr_req;
      end
    end
  end

  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    o_ent_valid = '0;
    o_ent_addr  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_ent_addr[k]  = r_mem[k].addr;
      o_ent_valid[k] = ({1'b0, (PW'(k) - r_rd_ptr)} < r_count);
    end
  end

endmodule

// File: rtl/css_mcu0_el2_dec_gpr_wb_arb.sv
// Writeback arbiter: per-source FIFOs feeding three registered GPR write ports,
// round-robin scan with same-address suppression within a cycle.
module css_mcu0_el2_dec_gpr_wb_arb
  import css_mcu0_el2_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [NSRC-1:0]       src_valid,
  output logic [NSRC-1:0]       src_ready,
  input  logic [NSRC-1:0][4:0]  src_addr,
  input  logic [NSRC-1:0][31:0] src_data,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  wen2,
  output logic [4:0]            waddr0,
  output logic [4:0]            waddr1,
  output logic [4:0]            waddr2,
  output logic [31:0]           wd0,
  output logic [31:0]           wd1,
  output logic [31:0]           wd2,
  output logic [31:1]           gpr_pend,
  output logic                  idle
);

  localparam int RW = $clog2(NSRC);
  localparam int NP = GPR_WB_PORTS;

  logic [NSRC-1:0]       w_full;
  logic [NSRC-1:0]       w_empty;
  logic [NSRC-1:0]       w_push;
  logic [NSRC-1:0]       w_pop;
  el2_gpr_wb_req_t       w_req        [NSRC];
  el2_gpr_wb_req_t       w_head       [NSRC];
  logic [DEPTH-1:0]      w_ent_valid  [NSRC];
  logic [DEPTH-1:0][4:0] w_ent_addr   [NSRC];
  logic [NP-1:0]         w_pv;
  logic [4:0]            w_paddr      [NP];
  logic [31:0]           w_pdata      [NP];
  logic [RW-1:0]         w_rr_nxt;
  logic [31:1]           w_pend;

  logic [RW-1:0]         r_rr_ptr;
  logic [NP-1:0]         r_wen;
  logic [4:0]            r_waddr      [NP];
  logic [31:0]           r_wd         [NP];

  assign src_ready = ~w_full;
  assign w_push    = src_valid & ~w_full;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_fifo
    assign w_req[gi] = {src_addr[gi], src_data[gi]};
    css_mcu0_el2_gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_l       (rst_l),
      .i_push      (w_push[gi]),
      .i_pop       (w_pop[gi]),
      .i_wr_req    (w_req[gi]),
      .o_full      (w_full[gi]),
      .o_empty     (w_empty[gi]),
      .o_head      (w_head[gi]),
      .o_ent_valid (w_ent_valid[gi]),
      .o_ent_addr  (w_ent_addr[gi])
    );
  end

  // round-robin grant scan; x0 heads are retired without using a port
  always_comb begin : p_arb
    logic [RW:0]   sum;
    logic [RW-1:0] idx;
    logic [1:0]    nport;
    logic          dup;
    logic          gnt_x0;
    logic          gnt_port;
    w_pop    = '0;
    w_pv     = '0;
    w_rr_nxt = r_rr_ptr;
    nport    = 2'd0;
    for (int p = 0; p < NP; p++) begin
      w_paddr[p] = 5'd0;
      w_pdata[p] = 32'd0;
    end
    for (int k = 0; k < NSRC; k++) begin
      sum = {1'b0, r_rr_ptr} + (RW+1)'(k);
      idx = (sum >= (RW+1)'(NSRC)) ? RW'(sum - (RW+1)'(NSRC)) : RW'(sum);
      dup = 1'b0;
      for (int p = 0; p < NP; p++) begin
        dup = dup | ((2'(p) < nport) && (w_paddr[p] == w_head[idx].addr));
      end
      gnt_x0   = !w_empty[idx] && (w_head[idx].addr == 5'd0);
      gnt_port = !w_empty[idx] && (w_head[idx].addr != 5'd0) && (nport < 2'd3) && !dup;
      if (gnt_port) begin
        w_pv[nport]    = 1'b1;
        w_paddr[nport] = w_head[idx].addr;
        w_pdata[nport] = w_head[idx].data;
        nport          = nport + 2'd1;
      end else begin
        nport = nport;
      end
      if (gnt_x0 || gnt_port) begin
        w_pop[idx] = 1'b1;
        w_rr_nxt   = (idx == RW'(NSRC-1)) ? RW'(0) : idx + RW'(1);
      end else begin
        w_pop[idx] = 1'b0;
      end
    end
  end

  // registered write ports; idle ports keep their last address/data
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rr_ptr <= '0;
      r_wen    <= '0;
      for (int p = 0; p < NP; p++) begin
        r_waddr[p] <= 5'd0;
        r_wd[p]    <= 32'd0;
      end
    end else begin
      r_rr_ptr <= w_rr_nxt;
      r_wen    <= w_pv;
      for (int p = 0; p < NP; p++) begin
        if (w_pv[p]) begin
          r_waddr[p] <= w_paddr[p];
          r_wd[p]    <= w_pdata[p];
        end
      end
    end
  end

  // pending map covers every queued slot plus writes on the ports this cycle
  always_comb begin
    w_pend = '0;
    for (int j = 1; j < 32; j++) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          w_pend[j] = w_pend[j] | (w_ent_valid[i][k] & (w_ent_addr[i][k] == 5'(j)));
        end
      end
      for (int p = 0; p < NP; p++) begin
        w_pend[j] = w_pend[j] | (r_wen[p] & (r_waddr[p] == 5'(j)));
      end
    end
  end

  assign gpr_pend = w_pend;
  assign idle     = (&w_empty) & ~(|r_wen);
  assign wen0     = r_wen[0];
  assign wen1     = r_wen[1];
  assign wen2     = r_wen[2];
  assign waddr0   = r_waddr[0];
  assign waddr1   = r_waddr[1];
  assign waddr2   = r_waddr[2];
  assign wd0      = r_wd[0];
  assign wd1      = r_wd[1];
  assign wd2      = r_wd[2];

endmodule

// File: tb/tb_css_mcu0_el2_dec_gpr_wb_arb.sv
// Directed bench for the GPR writeback arbiter (NSRC=4, DEPTH=2).
module tb_css_mcu0_el2_dec_gpr_wb_arb;

  localparam int NSRC  = 4;
  localparam int DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rst_l;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC-1:0]       src_ready;
  logic [NSRC-1:0][4:0]  src_addr;
  logic [NSRC-1:0][31:0] src_data;
  logic                  wen0, wen1, wen2;
  logic [4:0]            waddr0, waddr1, waddr2;
  logic [31:0]           wd0, wd1, wd2;
  logic [31:1]           gpr_pend;
  logic                  idle;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  css_mcu0_el2_dec_gpr_wb_arb #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l),
    .src_valid(src_valid), .src_ready(src_ready), .src_addr(src_addr), .src_data(src_data),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wd0(wd0), .wd1(wd1), .wd2(wd2),
    .gpr_pend(gpr_pend), .idle(idle)
  );

  css_mcu0_el2_dec_gpr_wb_arb_chk u_chk (
    .clk(clk), .rst_l(rst_l),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic drive(input int s, input logic [4:0] a, input logic [31:0] d);
    src_valid[s] = 1'b1;
    src_addr[s]  = a;
    src_data[s]  = d;
  endtask

  initial begin
    int   n3;
    int   acc;
    int   nwen;
    logic seen_stall;
    logic [31:0] q_out[$];

    clr_in();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;

    chk_eq("rst_wen", {wen0, wen1, wen2}, 3'b000);
    chk_eq("rst_waddr0", waddr0, 5'd0);
    chk_eq("rst_wd0", wd0, 32'd0);
    chk_eq("rst_pend", {gpr_pend, 1'b0}, 32'd0);
    chk_eq("rst_idle", idle, 1'b1);
    chk_eq("rst_ready", src_ready, 4'hF);

    // single write from src1
    drive(1, 5'd5, 32'hDEAD_BEEF);
    tick();
    clr_in();
    chk_eq("single_t1_pend", {gpr_pend, 1'b0}, 32'h0000_0020);
    chk_eq("single_t1_wen0", wen0, 1'b0);
    tick();
    chk_eq("single_t2_wen", {wen0, wen1, wen2}, 3'b100);
    chk_eq("single_t2_waddr0", waddr0, 5'd5);
    chk_eq("single_t2_wd0", wd0, 32'hDEAD_BEEF);
    chk_eq("single_t2_pend", {gpr_pend, 1'b0}, 32'h0000_0020);
    tick();
    chk_eq("single_t3_wen0", wen0, 1'b0);
    chk_eq("single_t3_pend", {gpr_pend, 1'b0}, 32'd0);
    chk_eq("single_t3_idle", idle, 1'b1);
    chk_eq("single_t3_hold", waddr0, 5'd5);

    // x0 write from src2: retired silently
    drive(2, 5'd0, 32'h0000_0055);
    tick();
    clr_in();
    chk_eq("x0_t1_idle", idle, 1'b0);
    chk_eq("x0_t1_pend", {gpr_pend, 1'b0}, 32'd0);
    chk_eq("x0_t1_wen", {wen0, wen1, wen2}, 3'b000);
    tick();
    chk_eq("x0_t2_wen", {wen0, wen1, wen2}, 3'b000);
    chk_eq("x0_t2_idle", idle, 1'b1);
    tick();
    chk_eq("x0_t3_wen", {wen0, wen1, wen2}, 3'b000);

    // src3 write moves the round-robin pointer back to 0
    drive(3, 5'd9, 32'h0000_0099);
    tick();
    clr_in();
    tick();
    chk_eq("s3_wen", {wen0, wen1, wen2}, 3'b100);
    chk_eq("s3_waddr0", waddr0, 5'd9);
    chk_eq("s3_wd0", wd0, 32'h0000_0099);
    tick();

    // four-way
    drive(0, 5'd1, 32'h11);
    drive(1, 5'd2, 32'h22);
    drive(2, 5'd3, 32'h33);
    drive(3, 5'd4, 32'h44);
    tick();
    clr_in();
    chk_eq("four_t1_pend", {gpr_pend, 1'b0}, 32'h0000_001E);
    chk_eq("four_t1_wen", {wen0, wen1, wen2}, 3'b000);
    tick();
    chk_eq("four_t2_wen", {wen0, wen1, wen2}, 3'b111);
    chk_eq("four_t2_waddr", {waddr0, waddr1, waddr2}, {5'd1, 5'd2, 5'd3});
    chk_eq("four_t2_wd01", {wd0, wd1}, {32'h11, 32'h22});
    chk_eq("four_t2_wd2", wd2, 32'h33);
    chk_eq("four_t2_pend", {gpr_pend, 1'b0}, 32'h0000_001E);
    tick();
    chk_eq("four_t3_wen", {wen0, wen1, wen2}, 3'b100);
    chk_eq("four_t3_waddr0", waddr0, 5'd4);
    chk_eq("four_t3_wd0", wd0, 32'h44);
    chk_eq("four_t3_pend", {gpr_pend, 1'b0}, 32'h0000_0010);
    tick();
    chk_eq("four_t4_idle", idle, 1'b1);

    // same-address collision, rr_ptr back at 0
    drive(0, 5'd7, 32'h1);
    drive(2, 5'd7, 32'h2);
    tick();
    clr_in();
    tick();
    chk_eq("coll_t2_wen", {wen0, wen1, wen2}, 3'b100);
    chk_eq("coll_t2_waddr0", waddr0, 5'd7);
    chk_eq("coll_t2_wd0", wd0, 32'h1);
    chk_eq("coll_t2_pend", {gpr_pend, 1'b0}, 32'h0000_0080);
    tick();
    chk_eq("coll_t3_wen", {wen0, wen1, wen2}, 3'b100);
    chk_eq("coll_t3_waddr0", waddr0, 5'd7);
    chk_eq("coll_t3_wd0", wd0, 32'h2);
    tick();
    chk_eq("coll_idle", idle, 1'b1);

    // backpressure: src3 streams six items while srcs 0..2 push every cycle
    n3         = 0;
    acc        = 0;
    nwen       = 0;
    seen_stall = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (n3 < 6) begin
        drive(0, 5'd10, 32'h1000_0000 + 32'(cyc));
        drive(1, 5'd11, 32'h1100_0000 + 32'(cyc));
        drive(2, 5'd12, 32'h1200_0000 + 32'(cyc));
        drive(3, 5'd20, 32'h3000_0000 + 32'(n3));
      end else begin
        clr_in();
      end
      if (src_valid[3] && !src_ready[3]) seen_stall = 1'b1;
      for (int i = 0; i < NSRC; i++) begin
        if (src_valid[i] && src_ready[i]) acc++;
      end
      if (src_valid[3] && src_ready[3]) n3++;
      tick();
      if (wen0) nwen++;
      if (wen1) nwen++;
      if (wen2) nwen++;
      if (wen0 && waddr0 == 5'd20) q_out.push_back(wd0);
      if (wen1 && waddr1 == 5'd20) q_out.push_back(wd1);
      if (wen2 && waddr2 == 5'd20) q_out.push_back(wd2);
      if (n3 >= 6 && idle) break;
    end
    clr_in();
    chk_eq("bp_stall_seen", seen_stall, 1'b1);
    chk_eq("bp_drained", idle, 1'b1);
    chk_eq("bp_s3_count", 64'(q_out.size()), 64'd6);
    for (int k = 0; k < q_out.size(); k++) begin
      chk_eq($sformatf("bp_s3_order%0d", k), q_out[k], 32'h3000_0000 + 32'(k));
    end
    chk_eq("bp_total_writes", 64'(nwen), 64'(acc));

    // reset with three FIFOs holding one entry each
    drive(0, 5'd13, 32'hAAAA_0013);
    drive(1, 5'd14, 32'hAAAA_0014);
    drive(2, 5'd15, 32'hAAAA_0015);
    tick();
    clr_in();
    chk_eq("mid_pre_pend", {gpr_pend, 1'b0}, 32'h0000_E000);
    rst_l = 1'b0;
    #1;
    chk_eq("mid_rst_wen", {wen0, wen1, wen2}, 3'b000);
    chk_eq("mid_rst_waddr0", waddr0, 5'd0);
    chk_eq("mid_rst_wd0", wd0, 32'd0);
    chk_eq("mid_rst_pend", {gpr_pend, 1'b0}, 32'd0);
    chk_eq("mid_rst_idle", idle, 1'b1);
    chk_eq("mid_rst_ready", src_ready, 4'hF);
    tick();
    rst_l = 1'b1;
    nwen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wen0 || wen1 || wen2) nwen++;
    end
    chk_eq("mid_post_no_wen", 64'(nwen), 64'd0);
    chk_eq("mid_post_idle", idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
